// File: rtl/edge_detect_filt_if.sv
// Bundle for the filtered multi-channel edge detector: raw inputs and controls in,
// filtered levels, edge pulses and sticky event flags out.
interface edge_detect_filt_if #(
    parameter int SIGCNT = 4
);
    logic                  tick;
    logic [SIGCNT-1:0]     signal_in;
    logic [2*SIGCNT-1:0]   edge_mode;
    logic [SIGCNT-1:0]     event_clr;

    logic [SIGCNT-1:0]     signal_filt;
    logic [SIGCNT-1:0]     detect_pe;
    logic [SIGCNT-1:0]     detect_ne;
    logic [SIGCNT-1:0]     detect_any;
    logic [SIGCNT-1:0]     event_pulse;
    logic [SIGCNT-1:0]     event_sticky;
    logic                  event_any;

    modport master (
        output tick, signal_in, edge_mode, event_clr,
        input  signal_filt, detect_pe, detect_ne, detect_any,
               event_pulse, event_sticky, event_any
    );

    modport slave (
        input  tick, signal_in, edge_mode, event_clr,
        output signal_filt, detect_pe, detect_ne, detect_any,
               event_pulse, event_sticky, event_any
    );
endinterface

// File: rtl/edge_detect_filt.sv
// Per-channel synchronizer, tick-qualified glitch filter, registered edge pulses
// and mode-gated sticky event flags for slow asynchronous board-status pins.
module edge_detect_filt #(
    parameter int                SIGCNT      = 4,
    parameter logic [SIGCNT-1:0] DEF_INIT    = {SIGCNT{1'b0}},
    parameter int                SYNC_STAGES = 2,
    parameter int                FILT_LEN    = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    edge_detect_filt_if.slave  bus
);
    localparam int            CW       = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic [SIGCNT-1:0] w_s;
    logic [SIGCNT-1:0] r_filt;
    logic [SIGCNT-1:0] r_pe;
    logic [SIGCNT-1:0] r_ne;
    logic [SIGCNT-1:0] r_sticky;
    logic [SIGCNT-1:0] w_event_pulse;
    logic [CW-1:0]     r_cnt [SIGCNT];

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = bus.signal_in;
        end else begin : g_sync
            logic [SIGCNT-1:0] r_sync [SYNC_STAGES];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= DEF_INIT;
                end else begin
                    r_sync[0] <= bus.signal_in;
                    for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
                end
            end

            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // Filter: any sample equal to the filtered state discards the partial count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt <= DEF_INIT;
            r_pe   <= '0;
            r_ne   <= '0;
            for (int i = 0; i < SIGCNT; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < SIGCNT; i++) begin
                r_pe[i] <= 1'b0;
                r_ne[i] <= 1'b0;
                if (w_s[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (bus.tick) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        r_cnt[i]  <= '0;
                        r_filt[i] <= w_s[i];
                        r_pe[i]   <= w_s[i];
                        r_ne[i]   <= ~w_s[i];
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_event_pulse = '0;
        for (int i = 0; i < SIGCNT; i++) begin
            w_event_pulse[i] = (bus.edge_mode[2*i]   & r_pe[i]) |
                               (bus.edge_mode[2*i+1] & r_ne[i]);
        end
    end

    // Set wins over clear so an event arriving with the clear is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (r_sticky & ~bus.event_clr) | w_event_pulse;
        end
    end

    assign bus.signal_filt  = r_filt;
    assign bus.detect_pe    = r_pe;
    assign bus.detect_ne    = r_ne;
    assign bus.detect_any   = r_pe | r_ne;
    assign bus.event_pulse  = w_event_pulse;
    assign bus.event_sticky = r_sticky;
    assign bus.event_any    = |r_sticky;
endmodule
